// File: rtl/systolic_pkg.sv
// Shared sizing defaults, bank/FSM state encodings and the debug view of the systolic feeder.
package systolic_pkg;

    localparam int TIME_STEPS   = 4;
    localparam int DEF_ROWS     = 16;
    localparam int DEF_COLS     = 16;
    localparam int DEF_DATA_W   = TIME_STEPS * 2;
    localparam int DEF_WEIGHT_W = 8;
    localparam int DEF_MLEN_W   = 10;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_LOADING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_BUSY    = 2'd3
    } bank_state_t;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_ROW  = 1'b1
    } load_state_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_ISSUE = 2'd1,
        C_DRAIN = 2'd2
    } calc_state_t;

    typedef struct packed {
        load_state_t load_state;
        calc_state_t calc_state;
        logic        load_ptr;
        logic        calc_ptr;
        bank_state_t bank0;
        bank_state_t bank1;
    } feeder_dbg_t;

endpackage

// File: rtl/systolic_skew_line.sv
// Valid+data delay line of DEPTH registers; one per array row to build the activation skew.
module systolic_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    localparam int EW = W + 1;

    logic [DEPTH*EW-1:0] shift_q;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst) shift_q <= '0;
            else     shift_q <= {in_valid, in_data};
        end
    end else begin : g_chain
        always_ff @(posedge clk) begin
            if (rst) shift_q <= '0;
            else     shift_q <= {shift_q[(DEPTH-1)*EW-1:0], in_valid, in_data};
        end
    end

    assign out_valid = shift_q[DEPTH*EW-1];
    assign out_data  = shift_q[(DEPTH-1)*EW +: W];

endmodule

// File: rtl/systolic_feeder.sv
// Weight ping-pong loader and skewed activation issuer for the PE grid.
// Optional SYSTOLIC_FEEDER_PERF_EN adds saturating stall/block counters.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int MLEN_W   = DEF_MLEN_W
) (
    input  logic                     s_clk,
    input  logic                     s_rst,
    // Handshakes: a beat/vector transfers on a rising edge where valid && ready;
    // ready never depends on valid, and valid/data must hold until transfer.
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [COLS*WEIGHT_W-1:0] w_data,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ROWS*DATA_W-1:0]   a_data,
    input  logic [MLEN_W-1:0]        cfg_m_len,
    output logic [ROWS-1:0]          pe_weight_valid,
    output logic [COLS*WEIGHT_W-1:0] pe_weights,
    output logic                     pe_load_ptr,
    output logic                     pe_calc_ptr,
    output logic [ROWS-1:0]          pe_data_valid,
    output logic [ROWS*DATA_W-1:0]   pe_raw_data,
    output logic                     pass_done,
    output feeder_dbg_t              dbg
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    output logic [31:0]              perf_a_stall,
    output logic [31:0]              perf_w_block
`endif
);

    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DRAIN_LEN = ROWS + COLS;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    load_state_t         load_state, load_state_nx;
    calc_state_t         calc_state, calc_state_nx;
    bank_state_t         bank_q [2];
    bank_state_t         bank_nx [2];
    logic                load_ptr, calc_ptr;
    logic [ROW_W-1:0]    row_cnt;
    logic [MLEN_W-1:0]   m_len, vec_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                w_accept, a_accept, row_last, vec_last;
    logic                calc_start, pass_release;
    logic [ROWS*DATA_W-1:0] a_gated;

    assign w_ready      = (bank_q[load_ptr] == BANK_EMPTY) || (bank_q[load_ptr] == BANK_LOADING);
    assign a_ready      = (calc_state == C_ISSUE);
    assign w_accept     = w_valid && w_ready;
    assign a_accept     = a_valid && a_ready;
    assign row_last     = (row_cnt == ROW_W'(ROWS - 1));
    assign vec_last     = ((vec_cnt + MLEN_W'(1)) == m_len);
    assign calc_start   = (calc_state == C_IDLE) && (bank_q[calc_ptr] == BANK_FULL) && (cfg_m_len != '0);
    assign pass_release = (calc_state == C_DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_LEN));
    assign pass_done    = pass_release;
    assign pe_calc_ptr  = calc_ptr;

    always_comb begin
        load_state_nx = load_state;
        case (load_state)
            L_IDLE:  if (w_accept && !row_last) load_state_nx = L_ROW;
            L_ROW:   if (w_accept && row_last)  load_state_nx = L_IDLE;
            default: load_state_nx = L_IDLE;
        endcase
    end

    always_comb begin
        calc_state_nx = calc_state;
        case (calc_state)
            C_IDLE:  if (calc_start)            calc_state_nx = C_ISSUE;
            C_ISSUE: if (a_accept && vec_last)  calc_state_nx = C_DRAIN;
            C_DRAIN: if (pass_release)          calc_state_nx = C_IDLE;
            default: calc_state_nx = C_IDLE;
        endcase
    end

    // Load and calc never touch the same bank in one cycle, so both updates may land together.
    always_comb begin
        bank_nx = bank_q;
        for (int b = 0; b < 2; b++) begin
            if (w_accept && (load_ptr == b[0]))
                bank_nx[b] = row_last ? BANK_FULL : BANK_LOADING;
            if (calc_start && (calc_ptr == b[0]))
                bank_nx[b] = BANK_BUSY;
            if (pass_release && (calc_ptr == b[0]))
                bank_nx[b] = BANK_EMPTY;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            load_state      <= L_IDLE;
            calc_state      <= C_IDLE;
            bank_q[0]       <= BANK_EMPTY;
            bank_q[1]       <= BANK_EMPTY;
            load_ptr        <= 1'b0;
            calc_ptr        <= 1'b0;
            row_cnt         <= '0;
            m_len           <= '0;
            vec_cnt         <= '0;
            drain_cnt       <= '0;
            pe_weight_valid <= '0;
            pe_weights      <= '0;
            pe_load_ptr     <= 1'b0;
        end else begin
            load_state <= load_state_nx;
            calc_state <= calc_state_nx;
            bank_q[0]  <= bank_nx[0];
            bank_q[1]  <= bank_nx[1];
            if (w_accept) begin
                row_cnt <= row_last ? '0 : row_cnt + ROW_W'(1);
                if (row_last) load_ptr <= ~load_ptr;
            end
            if (calc_start) begin
                m_len   <= cfg_m_len;
                vec_cnt <= '0;
            end else if (a_accept) begin
                vec_cnt <= vec_cnt + MLEN_W'(1);
            end
            drain_cnt <= (calc_state == C_DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;
            if (pass_release) calc_ptr <= ~calc_ptr;
            pe_weight_valid <= w_accept ? (ROWS'(1) << row_cnt) : '0;
            if (w_accept) pe_weights <= w_data;
            // Delayed so the pointer lines up with the weight row it accompanies.
            pe_load_ptr <= load_ptr;
        end
    end

    assign a_gated = a_accept ? a_data : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        systolic_skew_line #(
            .DEPTH (r + 1),
            .W     (DATA_W)
        ) u_skew (
            .clk       (s_clk),
            .rst       (s_rst),
            .in_valid  (a_accept),
            .in_data   (a_gated[r*DATA_W +: DATA_W]),
            .out_valid (pe_data_valid[r]),
            .out_data  (pe_raw_data[r*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        dbg            = '0;
        dbg.load_state = load_state;
        dbg.calc_state = calc_state;
        dbg.load_ptr   = load_ptr;
        dbg.calc_ptr   = calc_ptr;
        dbg.bank0      = bank_q[0];
        dbg.bank1      = bank_q[1];
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            perf_a_stall <= '0;
            perf_w_block <= '0;
        end else begin
            if ((calc_state == C_ISSUE) && !a_valid && (perf_a_stall != '1))
                perf_a_stall <= perf_a_stall + 32'd1;
            if (w_valid && !w_ready && (perf_w_block != '1))
                perf_w_block <= perf_w_block + 32'd1;
        end
    end
`endif

endmodule
